// File: rtl/picorv32_pcpi_issuer.sv
// ============================================================================
// Module      : picorv32_pcpi_issuer
// Description : PCPI initiator with a no-claim watchdog that raises an
//               illegal-instruction trap. Optional PCPI_PERF_CNT_EN adds
//               op/trap/busy counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module picorv32_pcpi_issuer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [31:0] issue_insn,
    input  logic [31:0] issue_rs1,
    input  logic [31:0] issue_rs2,

    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready,

`ifdef PCPI_PERF_CNT_EN
    output logic [31:0] perf_ops,
    output logic [31:0] perf_traps,
    output logic [31:0] perf_busy,
`endif

    output logic        done_valid,
    output logic        done_wr,
    output logic [31:0] done_rd,
    output logic        done_trap
);

    // A zero timeout still needs a one-bit counter; it simply never loads a
    // non-zero value, so the watchdog can never fire.
    localparam int              c_CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam bit              c_TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_issue_ready;
    logic                r_pcpi_valid;
    logic [31:0]         r_insn;
    logic [31:0]         r_rs1;
    logic [31:0]         r_rs2;
    logic                r_done_valid;
    logic                r_done_wr;
    logic [31:0]         r_done_rd;
    logic                r_done_trap;

    logic                w_accept;
    logic                w_expire;
    logic [c_CNT_W-1:0]  w_cnt_dec;

    assign w_accept  = issue_valid && r_issue_ready;
    // Expiry is the silent cycle that would take the counter from 1 to 0.
    assign w_expire  = c_TIMEOUT_EN && (r_cnt == c_CNT_ONE);
    assign w_cnt_dec = (r_cnt != '0) ? (r_cnt - c_CNT_ONE) : r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_issue_ready <= 1'b1;
            r_pcpi_valid  <= 1'b0;
            r_insn        <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_done_valid  <= 1'b0;
            r_done_wr     <= 1'b0;
            r_done_rd     <= '0;
            r_done_trap   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state       <= S_REQ;
                        r_insn        <= issue_insn;
                        r_rs1         <= issue_rs1;
                        r_rs2         <= issue_rs2;
                        r_cnt         <= c_CNT_LOAD;
                        r_issue_ready <= 1'b0;
                        r_pcpi_valid  <= 1'b1;
                    end
                end
                S_REQ: begin
                    // Ready takes priority over a simultaneous watchdog expiry.
                    if (pcpi_ready) begin
                        r_state      <= S_DONE;
                        r_pcpi_valid <= 1'b0;
                        r_done_valid <= 1'b1;
                        r_done_wr    <= pcpi_wr;
                        r_done_rd    <= pcpi_rd;
                        r_done_trap  <= 1'b0;
                    end else if (pcpi_wait) begin
                        r_cnt <= c_CNT_LOAD;
                    end else if (w_expire) begin
                        r_state      <= S_DONE;
                        r_cnt        <= '0;
                        r_pcpi_valid <= 1'b0;
                        r_done_valid <= 1'b1;
                        r_done_wr    <= 1'b0;
                        r_done_rd    <= '0;
                        r_done_trap  <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_dec;
                    end
                end
                S_DONE: begin
                    r_state       <= S_IDLE;
                    r_issue_ready <= 1'b1;
                    r_done_valid  <= 1'b0;
                    r_done_wr     <= 1'b0;
                    r_done_rd     <= '0;
                    r_done_trap   <= 1'b0;
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_issue_ready <= 1'b1;
                    r_pcpi_valid  <= 1'b0;
                    r_done_valid  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PCPI_PERF_CNT_EN
    logic [31:0] r_perf_ops;
    logic [31:0] r_perf_traps;
    logic [31:0] r_perf_busy;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_perf_ops   <= '0;
            r_perf_traps <= '0;
            r_perf_busy  <= '0;
        end else begin
            if (r_done_valid && !r_done_trap)
                r_perf_ops <= r_perf_ops + 32'd1;
            if (r_done_valid && r_done_trap)
                r_perf_traps <= r_perf_traps + 32'd1;
            if (r_state == S_REQ)
                r_perf_busy <= r_perf_busy + 32'd1;
        end
    end

    assign perf_ops   = r_perf_ops;
    assign perf_traps = r_perf_traps;
    assign perf_busy  = r_perf_busy;
`endif

    assign issue_ready = r_issue_ready;
    assign pcpi_valid  = r_pcpi_valid;
    assign pcpi_insn   = r_insn;
    assign pcpi_rs1    = r_rs1;
    assign pcpi_rs2    = r_rs2;
    assign done_valid  = r_done_valid;
    assign done_wr     = r_done_wr;
    assign done_rd     = r_done_rd;
    assign done_trap   = r_done_trap;

endmodule

`default_nettype wire
